// File: rtl/uart_msg_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_msg_tx : sends a compile-time byte string as UART frames      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module uart_msg_tx #(
  parameter int                   CLOCKS_PER_BIT = 10,
  parameter int                   MSG_LEN        = 11,
  parameter logic [8*MSG_LEN-1:0] MSG            = "hello world",
  parameter int                   PARITY         = 0,
  parameter int                   STOP_BITS      = 1,
  parameter int                   IDX_W          = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trigger,
  input  logic             repeat_en,
  input  logic             abort,
  output logic             busy,
  output logic             tx,
  output logic [7:0]       data,
  output logic [IDX_W-1:0] char_index,
  output logic             done
);

  localparam int               CNT_W       = (CLOCKS_PER_BIT > 2) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST  = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] C_CNT_DONE  = CNT_W'(CLOCKS_PER_BIT - 2);
  localparam logic [IDX_W-1:0] C_IDX_LAST  = IDX_W'(MSG_LEN - 1);
  localparam logic             C_HAS_PAR   = (PARITY != 0);
  localparam logic             C_ODD_PAR   = (PARITY == 1);
  localparam logic             C_STOP_LAST = (STOP_BITS == 2);

  if (CLOCKS_PER_BIT < 2) begin : g_chk_cpb
    $error("uart_msg_tx: CLOCKS_PER_BIT must be >= 2");
  end
  if (MSG_LEN < 1) begin : g_chk_len
    $error("uart_msg_tx: MSG_LEN must be >= 1");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_chk_stop
    $error("uart_msg_tx: STOP_BITS must be 1 or 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_chk_par
    $error("uart_msg_tx: PARITY must be 0, 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic             r_stop_idx;
  logic             r_abort;

  logic             w_cnt_end;
  logic             w_last_char;
  logic             w_stop_last;
  logic             w_abort_req;
  logic             w_par_bit;
  logic [IDX_W-1:0] w_next_idx;
  logic [7:0]       w_next_byte;

  // Character 0 sits in the most significant byte of MSG.
  function automatic logic [7:0] msg_byte(input logic [IDX_W-1:0] idx);
    logic [8*MSG_LEN-1:0] sh;
    sh = MSG >> (8 * (MSG_LEN - 1 - int'(idx)));
    return sh[7:0];
  endfunction

  assign w_cnt_end   = (r_cnt == C_CNT_LAST);
  assign w_last_char = (char_index == C_IDX_LAST);
  assign w_stop_last = (r_stop_idx == C_STOP_LAST);
  assign w_abort_req = r_abort | abort;
  assign w_par_bit   = C_ODD_PAR ? ~^data : ^data;
  assign w_next_idx  = w_last_char ? '0 : char_index + 1'b1;
  assign w_next_byte = msg_byte(w_next_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_abort    <= 1'b0;
      busy       <= 1'b0;
      tx         <= 1'b1;
      data       <= '0;
      char_index <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (r_state != S_IDLE) begin
        r_cnt <= w_cnt_end ? '0 : r_cnt + 1'b1;
        if (abort) r_abort <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (trigger) begin
            r_state    <= S_START;
            r_cnt      <= '0;
            r_abort    <= 1'b0;
            busy       <= 1'b1;
            tx         <= 1'b0;
            char_index <= '0;
            data       <= msg_byte('0);
          end
        end
        S_START: begin
          if (w_cnt_end) begin
            r_state   <= S_DATA;
            r_bit_idx <= '0;
            tx        <= data[0];
          end
        end
        S_DATA: begin
          if (w_cnt_end) begin
            if (r_bit_idx == 3'd7) begin
              if (C_HAS_PAR) begin
                r_state <= S_PARITY;
                tx      <= w_par_bit;
              end else begin
                r_state    <= S_STOP;
                r_stop_idx <= 1'b0;
                tx         <= 1'b1;
              end
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              tx        <= data[r_bit_idx + 3'd1];
            end
          end
        end
        S_PARITY: begin
          if (w_cnt_end) begin
            r_state    <= S_STOP;
            r_stop_idx <= 1'b0;
            tx         <= 1'b1;
          end
        end
        S_STOP: begin
          // Raised one cycle early so the registered pulse lands on the final stop cycle.
          if (w_stop_last && w_last_char && r_cnt == C_CNT_DONE) done <= 1'b1;
          if (w_cnt_end) begin
            if (!w_stop_last) begin
              r_stop_idx <= 1'b1;
            end else if (w_abort_req || (w_last_char && !repeat_en)) begin
              r_state <= S_IDLE;
              r_abort <= 1'b0;
              busy    <= 1'b0;
              tx      <= 1'b1;
            end else begin
              r_state    <= S_START;
              tx         <= 1'b0;
              char_index <= w_next_idx;
              data       <= w_next_byte;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          tx      <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
